// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
//
// Branch prediction unit for the 5-stage RV32I pipeline. The IF stage looks up
// a direct-mapped BTB plus a pattern history table (PHT) of saturating
// counters. The EX stage resolves each control-flow instruction, trains the
// tables, and raises a flush with the correct next PC when the prediction that
// travelled down the pipe turns out to be wrong.
//
// Indexing is bimodal when GHR_W = 0. When GHR_W is 1..IDX_W it is gshare: the
// PHT index is the PC index XORed with the global history register.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   if_pc_i             PC being fetched
//   pred_taken_o        predicted taken
//   pred_target_o       predicted next PC
//   pred_ghr_o          GHR snapshot that travels with the instruction
//   ex_valid_i          EX holds a real instruction
//   ex_is_branch_i      conditional B-type instruction in EX
//   ex_is_jump_i        jal/jalr instruction in EX
//   ex_pc_i             PC of the EX instruction
//   ex_taken_i          actual outcome
//   ex_target_i         actual target
//   ex_pred_taken_i     prediction carried from IF
//   ex_pred_target_i    predicted target carried from IF
//   ex_ghr_i            GHR snapshot carried from IF
//   flush_o             mispredict: kill IF/ID and ID/EX
//   redirect_pc_o       correct next PC, valid when flush_o = 1
//   stat_branches_o     saturating count of resolved control-flow instructions
//   stat_mispred_o      saturating count of mispredicts
// ----------------------------------------------------------------------------
module branch_predictor #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6,
    parameter int CTR_W  = 2,
    parameter int GHR_W  = 0,
    parameter int STAT_W = 32,
    localparam int GW    = (GHR_W > 0) ? GHR_W : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] if_pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    output logic [GW-1:0]     pred_ghr_o,
    input  logic              ex_valid_i,
    input  logic              ex_is_branch_i,
    input  logic              ex_is_jump_i,
    input  logic [ADDR_W-1:0] ex_pc_i,
    input  logic              ex_taken_i,
    input  logic [ADDR_W-1:0] ex_target_i,
    input  logic              ex_pred_taken_i,
    input  logic [ADDR_W-1:0] ex_pred_target_i,
    input  logic [GW-1:0]     ex_ghr_i,
    output logic              flush_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic [STAT_W-1:0] stat_branches_o,
    output logic [STAT_W-1:0] stat_mispred_o
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = ADDR_W - IDX_W - 2;

    // Weakly not-taken is the MSB clear with every lower bit set.
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

    // Prediction tables and committed history
    logic [ENTRIES-1:0] btbValid_q;
    logic [ENTRIES-1:0] btbJump_q;
    logic [TAG_W-1:0]   btbTag_q    [ENTRIES];
    logic [ADDR_W-1:0]  btbTarget_q [ENTRIES];
    logic [CTR_W-1:0]   pht_q       [ENTRIES];
    logic [GW-1:0]      ghr_q, ghr_d;
    logic [STAT_W-1:0]  statBranches_q, statBranches_d;
    logic [STAT_W-1:0]  statMispred_q, statMispred_d;

    // Lookup side
    logic [IDX_W-1:0]   ifIdx;
    logic [TAG_W-1:0]   ifTag;
    logic [IDX_W-1:0]   ifPhtIdx;
    logic               ifHit;

    // Resolution side
    logic [IDX_W-1:0]   exIdx;
    logic [TAG_W-1:0]   exTag;
    logic [IDX_W-1:0]   exPhtIdx;
    logic [CTR_W-1:0]   ctrCur, ctr_d;
    logic               resolve;
    logic               mispredict;

    // Instructions are word aligned, so PC bits [1:0] never take part in
    // indexing or tag comparison.
    logic               unusedPcBits;
    assign unusedPcBits = ^{if_pc_i[1:0], ex_pc_i[1:0]};

    // PHT index: plain PC index for bimodal, PC index XOR zero-padded history
    // for gshare. The history only ever reaches the low GW bits of the index.
    function automatic logic [IDX_W-1:0] phtIndex(input logic [ADDR_W-1:0] pc,
                                                 input logic [GW-1:0]     ghr);
        logic [IDX_W-1:0] hist;
        hist = '0;
        if (GHR_W > 0) begin
            hist[GW-1:0] = ghr;
        end
        return pc[IDX_W+1:2] ^ hist;
    endfunction

    // IF-stage lookup. This is purely combinational on the registered tables,
    // so an update made by EX in the same cycle only shows up next cycle.
    // A jump hit is always taken; a branch hit follows its counter MSB.
    always_comb begin
        ifIdx         = if_pc_i[IDX_W+1:2];
        ifTag         = if_pc_i[ADDR_W-1:IDX_W+2];
        ifPhtIdx      = phtIndex(if_pc_i, ghr_q);
        ifHit         = btbValid_q[ifIdx] && (btbTag_q[ifIdx] == ifTag);
        pred_taken_o  = ifHit && (btbJump_q[ifIdx] || pht_q[ifPhtIdx][CTR_W-1]);
        pred_target_o = pred_taken_o ? btbTarget_q[ifIdx] : (if_pc_i + ADDR_W'(4));
        pred_ghr_o    = (GHR_W > 0) ? ghr_q : '0;
    end

    // EX-stage resolution. A wrong direction is always a mispredict; a wrong
    // target only matters when the instruction was actually taken. The
    // redirect PC is driven every cycle so the pipeline can mux it blindly.
    always_comb begin
        resolve       = ex_valid_i && (ex_is_branch_i || ex_is_jump_i);
        mispredict    = resolve && ((ex_taken_i != ex_pred_taken_i) ||
                                    (ex_taken_i && (ex_target_i != ex_pred_target_i)));
        flush_o       = mispredict;
        redirect_pc_o = ex_taken_i ? ex_target_i : (ex_pc_i + ADDR_W'(4));
    end

    // Next-state values for the training path. The counter saturates at both
    // ends, the history shifts the outcome in at the LSB (the cast drops the
    // oldest bit), and the statistics stick at all-ones instead of wrapping.
    // The history index comes from the snapshot carried with the instruction,
    // so training hits the same counter that produced the prediction.
    always_comb begin
        exIdx    = ex_pc_i[IDX_W+1:2];
        exTag    = ex_pc_i[ADDR_W-1:IDX_W+2];
        exPhtIdx = phtIndex(ex_pc_i, ex_ghr_i);
        ctrCur   = pht_q[exPhtIdx];

        ctr_d = ctrCur;
        if (ex_taken_i && (ctrCur != CTR_MAX)) begin
            ctr_d = ctrCur + CTR_W'(1);
        end else if (!ex_taken_i && (ctrCur != '0)) begin
            ctr_d = ctrCur - CTR_W'(1);
        end

        ghr_d = ghr_q;
        if (GHR_W > 0) begin
            ghr_d = GW'({ghr_q, ex_taken_i});
        end

        statBranches_d = statBranches_q;
        if (statBranches_q != {STAT_W{1'b1}}) begin
            statBranches_d = statBranches_q + STAT_W'(1);
        end

        statMispred_d = statMispred_q;
        if (mispredict && (statMispred_q != {STAT_W{1'b1}})) begin
            statMispred_d = statMispred_q + STAT_W'(1);
        end
    end

    // Control state: valid/jump bits, counters, history and statistics.
    // Reset wins over any update presented in the same cycle. Only conditional
    // branches train the PHT and history; only taken instructions allocate a
    // BTB entry, and a not-taken outcome leaves any existing entry alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btbValid_q     <= '0;
            btbJump_q      <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= CTR_INIT;
            end
            ghr_q          <= '0;
            statBranches_q <= '0;
            statMispred_q  <= '0;
        end else if (resolve) begin
            statBranches_q <= statBranches_d;
            statMispred_q  <= statMispred_d;
            if (ex_is_branch_i) begin
                pht_q[exPhtIdx] <= ctr_d;
                ghr_q           <= ghr_d;
            end
            if (ex_taken_i) begin
                btbValid_q[exIdx] <= 1'b1;
                btbJump_q[exIdx]  <= ex_is_jump_i;
            end
        end
    end

    // BTB payload. It has no reset because an entry is never used until its
    // valid bit is set, and it is written alongside that valid bit.
    always_ff @(posedge clk) begin
        if (rst_n && resolve && ex_taken_i) begin
            btbTag_q[exIdx]    <= exTag;
            btbTarget_q[exIdx] <= ex_target_i;
        end
    end

    assign stat_branches_o = statBranches_q;
    assign stat_mispred_o  = statMispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed bench for branch_predictor. A bimodal instance (defaults) is driven
// from a table of hand-computed vectors covering reset, a taken branch, a jal,
// counter saturation, aliasing, a target mismatch, a bubble and PC wrap. A
// gshare instance (GHR_W = 4) sharing the same inputs runs an alternating
// branch sequence, and a final sequence asserts reset during an update.
// ----------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] ifPc;
    logic        exValid, exBranch, exJump, exTaken, exPredTaken;
    logic [31:0] exPc, exTarget, exPredTarget;
    logic [3:0]  exGhr;

    // Bimodal instance outputs
    logic        bPredTaken, bFlush;
    logic [31:0] bPredTarget, bRedirect, bStatBr, bStatMis;
    logic [0:0]  bPredGhr;

    // Gshare instance outputs
    logic        gPredTaken, gFlush;
    logic [31:0] gPredTarget, gRedirect, gStatBr, gStatMis;
    logic [3:0]  gPredGhr;

    int checks   = 0;
    int failures = 0;

    branch_predictor dutBimodal (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc_i          (ifPc),
        .pred_taken_o     (bPredTaken),
        .pred_target_o    (bPredTarget),
        .pred_ghr_o       (bPredGhr),
        .ex_valid_i       (exValid),
        .ex_is_branch_i   (exBranch),
        .ex_is_jump_i     (exJump),
        .ex_pc_i          (exPc),
        .ex_taken_i       (exTaken),
        .ex_target_i      (exTarget),
        .ex_pred_taken_i  (exPredTaken),
        .ex_pred_target_i (exPredTarget),
        .ex_ghr_i         (exGhr[0:0]),
        .flush_o          (bFlush),
        .redirect_pc_o    (bRedirect),
        .stat_branches_o  (bStatBr),
        .stat_mispred_o   (bStatMis)
    );

    branch_predictor #(.GHR_W(4)) dutGshare (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc_i          (ifPc),
        .pred_taken_o     (gPredTaken),
        .pred_target_o    (gPredTarget),
        .pred_ghr_o       (gPredGhr),
        .ex_valid_i       (exValid),
        .ex_is_branch_i   (exBranch),
        .ex_is_jump_i     (exJump),
        .ex_pc_i          (exPc),
        .ex_taken_i       (exTaken),
        .ex_target_i      (exTarget),
        .ex_pred_taken_i  (exPredTaken),
        .ex_pred_target_i (exPredTarget),
        .ex_ghr_i         (exGhr),
        .flush_o          (gFlush),
        .redirect_pc_o    (gRedirect),
        .stat_branches_o  (gStatBr),
        .stat_mispred_o   (gStatMis)
    );

    // 10 ns clock; inputs change on the falling edge, outputs sampled 2 ns later
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ifPc;
        logic        exValid, exBranch, exJump, exTaken, exPredTaken;
        logic [31:0] exPc, exTarget, exPredTarget;
        logic        expPredTaken;
        logic [31:0] expPredTarget;
        logic        expFlush;
        logic [31:0] expRedirect, expStatBr, expStatMis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(logic [31:0] ifPcV, logic v, logic br, logic j,
                                   logic [31:0] pc, logic t, logic [31:0] tgt,
                                   logic pt, logic [31:0] ptgt,
                                   logic ePt, logic [31:0] ePtgt, logic eFl,
                                   logic [31:0] eRd, logic [31:0] eBr, logic [31:0] eMis);
        vec_t r;
        r.ifPc = ifPcV; r.exValid = v; r.exBranch = br; r.exJump = j;
        r.exPc = pc; r.exTaken = t; r.exTarget = tgt;
        r.exPredTaken = pt; r.exPredTarget = ptgt;
        r.expPredTaken = ePt; r.expPredTarget = ePtgt; r.expFlush = eFl;
        r.expRedirect = eRd; r.expStatBr = eBr; r.expStatMis = eMis;
        return r;
    endfunction

    // A cycle with nothing in EX: redirect is exPc(0)+4
    function automatic vec_t mkIdle(logic [31:0] ifPcV, logic ePt, logic [31:0] ePtgt,
                                    logic [31:0] eBr, logic [31:0] eMis);
        return mkVec(ifPcV, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0,
                     ePt, ePtgt, 0, 32'h4, eBr, eMis);
    endfunction

    // Compare one value and record the result
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive all inputs of one vector
    task automatic applyStimulus(input vec_t v);
        ifPc         = v.ifPc;
        exValid      = v.exValid;
        exBranch     = v.exBranch;
        exJump       = v.exJump;
        exPc         = v.exPc;
        exTaken      = v.exTaken;
        exTarget     = v.exTarget;
        exPredTaken  = v.exPredTaken;
        exPredTarget = v.exPredTarget;
        exGhr        = 4'h0;
    endtask

    task automatic checkVector(input int n, input vec_t v);
        checkOutput($sformatf("v%0d.pred_taken", n),  {31'b0, bPredTaken}, {31'b0, v.expPredTaken});
        checkOutput($sformatf("v%0d.pred_target", n), bPredTarget, v.expPredTarget);
        checkOutput($sformatf("v%0d.flush", n),       {31'b0, bFlush}, {31'b0, v.expFlush});
        checkOutput($sformatf("v%0d.redirect", n),    bRedirect, v.expRedirect);
        checkOutput($sformatf("v%0d.stat_br", n),     bStatBr, v.expStatBr);
        checkOutput($sformatf("v%0d.stat_mis", n),    bStatMis, v.expStatMis);
    endtask

    logic        capTaken;
    logic [31:0] capTarget;
    logic [3:0]  capGhr;
    logic [3:0]  expGhr;
    logic        outcome;

    initial begin
        // Bimodal table: idx(0x100) = idx(0x200) = 0, tags 1 and 2
        // jal 0x200 -> 0x400 first, with its PHT counter still weakly not-taken
        vecs.push_back(mkIdle(32'h100, 0, 32'h104, 0, 0));
        vecs.push_back(mkVec(32'h200, 1, 0, 1, 32'h200, 1, 32'h400, 0, 32'h204,
                             0, 32'h204, 1, 32'h400, 0, 0));
        vecs.push_back(mkIdle(32'h200, 1, 32'h400, 1, 1));
        vecs.push_back(mkVec(32'h200, 1, 0, 1, 32'h200, 1, 32'h400, 1, 32'h400,
                             1, 32'h400, 0, 32'h400, 1, 1));
        // Taken branch 0x100 -> 0x80, mispredicted; replaces the jal entry
        vecs.push_back(mkVec(32'h100, 1, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104,
                             0, 32'h104, 1, 32'h80, 2, 1));
        vecs.push_back(mkIdle(32'h100, 1, 32'h80, 3, 2));
        // Four more correct taken resolutions: counter saturates at 3
        vecs.push_back(mkVec(32'h100, 1, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80,
                             1, 32'h80, 0, 32'h80, 3, 2));
        vecs.push_back(mkVec(32'h100, 1, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80,
                             1, 32'h80, 0, 32'h80, 4, 2));
        vecs.push_back(mkVec(32'h100, 1, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80,
                             1, 32'h80, 0, 32'h80, 5, 2));
        vecs.push_back(mkVec(32'h100, 1, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80,
                             1, 32'h80, 0, 32'h80, 6, 2));
        // Not taken: 3 -> 2, still predicted taken
        vecs.push_back(mkVec(32'h100, 1, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80,
                             1, 32'h80, 1, 32'h104, 7, 2));
        vecs.push_back(mkIdle(32'h100, 1, 32'h80, 8, 3));
        // Not taken again: 2 -> 1, now predicted not taken despite the BTB hit
        vecs.push_back(mkVec(32'h100, 1, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80,
                             1, 32'h80, 1, 32'h104, 8, 3));
        vecs.push_back(mkIdle(32'h100, 0, 32'h104, 9, 4));
        // Aliasing: taken branch 0x200 -> 0x300 overwrites entry 0 (counter -> 2)
        vecs.push_back(mkVec(32'h100, 1, 1, 0, 32'h200, 1, 32'h300, 0, 32'h204,
                             0, 32'h104, 1, 32'h300, 9, 4));
        vecs.push_back(mkIdle(32'h100, 0, 32'h104, 10, 5));
        vecs.push_back(mkIdle(32'h200, 1, 32'h300, 10, 5));
        // Right direction, wrong target is still a mispredict
        vecs.push_back(mkVec(32'h200, 1, 1, 0, 32'h200, 1, 32'h340, 1, 32'h300,
                             1, 32'h300, 1, 32'h340, 10, 5));
        // Bubble in EX: no flush, redirect still driven, no state change
        vecs.push_back(mkVec(32'h200, 0, 1, 0, 32'h200, 1, 32'h500, 0, 32'h204,
                             1, 32'h340, 0, 32'h500, 11, 6));
        vecs.push_back(mkIdle(32'h200, 1, 32'h340, 11, 6));
        // Fall-through PC wraps modulo 2**32
        vecs.push_back(mkIdle(32'hFFFF_FFFC, 0, 32'h0, 11, 6));

        applyStimulus(mkIdle(32'h100, 0, 32'h104, 0, 0));
        rst_n = 1'b0;

        // Reset state, observed while reset is still held
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        checkOutput("reset.pred_taken",  {31'b0, bPredTaken}, 32'h0);
        checkOutput("reset.pred_target", bPredTarget, 32'h104);
        checkOutput("reset.flush",       {31'b0, bFlush}, 32'h0);
        checkOutput("reset.stat_br",     bStatBr, 32'h0);
        checkOutput("reset.stat_mis",    bStatMis, 32'h0);
        checkOutput("reset.gshare_ghr",  {28'b0, gPredGhr}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            checkVector(i, vecs[i]);
        end

        // Gshare: alternating T/N branch at 0x40 -> 0x80. Each iteration looks
        // up in one cycle and resolves with the carried snapshot in the next.
        // The first six iterations warm up (T,T,T mispredict), the next eight
        // must predict perfectly.
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(mkIdle(32'h40, 0, 32'h44, 0, 0));
        @(negedge clk);
        rst_n  = 1'b1;
        expGhr = 4'h0;
        for (int it = 0; it < 14; it++) begin
            outcome = (it % 2 == 0);
            @(negedge clk);
            ifPc    = 32'h40;
            exValid = 1'b0;
            #2;
            capTaken  = gPredTaken;
            capTarget = gPredTarget;
            capGhr    = gPredGhr;
            checkOutput($sformatf("gs%0d.pred_ghr", it), {28'b0, gPredGhr}, {28'b0, expGhr});
            if (it >= 6) begin
                checkOutput($sformatf("gs%0d.pred_taken", it), {31'b0, gPredTaken}, {31'b0, outcome});
                checkOutput($sformatf("gs%0d.pred_target", it), gPredTarget,
                            outcome ? 32'h80 : 32'h44);
            end
            @(negedge clk);
            exValid      = 1'b1;
            exBranch     = 1'b1;
            exJump       = 1'b0;
            exPc         = 32'h40;
            exTaken      = outcome;
            exTarget     = 32'h80;
            exPredTaken  = capTaken;
            exPredTarget = capTarget;
            exGhr        = capGhr;
            #2;
            if (it >= 6) begin
                checkOutput($sformatf("gs%0d.flush", it), {31'b0, gFlush}, 32'h0);
            end
            expGhr = {expGhr[2:0], outcome};
        end
        @(negedge clk);
        exValid = 1'b0;
        #2;
        checkOutput("gs.stat_br",  gStatBr, 32'd14);
        checkOutput("gs.stat_mis", gStatMis, 32'd3);

        // Reset asserted while a taken branch 0x200 resolves: reset must win
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(mkVec(32'h200, 1, 1, 0, 32'h200, 1, 32'h600, 0, 32'h204,
                            0, 32'h0, 0, 32'h0, 0, 0));
        @(negedge clk);
        rst_n   = 1'b1;
        exValid = 1'b0;
        ifPc    = 32'h200;
        #2;
        checkOutput("rstupd.pred_taken",  {31'b0, bPredTaken}, 32'h0);
        checkOutput("rstupd.pred_target", bPredTarget, 32'h204);
        checkOutput("rstupd.stat_br",     bStatBr, 32'h0);
        checkOutput("rstupd.stat_mis",    bStatMis, 32'h0);
        checkOutput("rstupd.gshare_ghr",  {28'b0, gPredGhr}, 32'h0);
        checkOutput("rstupd.gshare_br",   gStatBr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
